// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the cache-to-memory arbiter
package mem_arbiter_pkg;

    localparam int CACHE_LINE_BYTES = 16;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD,
        SIZE_LINE
    } access_size_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_IC,
        ISSUE_DC_RD,
        ISSUE_DC_WR,
        RESP
    } arb_state_t;

    typedef enum logic {
        SRC_IC,
        SRC_DC
    } arb_src_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the arbiter, master = arbiter
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);

    logic                  ic_rd_req_i;
    logic [ADDR_WIDTH-1:0] ic_addr_i;
    logic                  ic_data_valid_o;
    logic [LINE_WIDTH-1:0] ic_data_o;
    logic                  dc_rd_req_i;
    logic                  dc_wr_req_i;
    logic [ADDR_WIDTH-1:0] dc_addr_i;
    logic [LINE_WIDTH-1:0] dc_wr_data_i;
    access_size_t          dc_access_size_i;
    logic                  dc_data_valid_o;
    logic [LINE_WIDTH-1:0] dc_data_o;
    logic                  dc_wr_done_o;
    logic                  mem_rd_req_valid_o;
    logic                  mem_wr_req_valid_o;
    logic                  mem_req_is_instr_o;
    logic [ADDR_WIDTH-1:0] mem_req_address_o;
    logic [LINE_WIDTH-1:0] mem_wr_data_o;
    access_size_t          mem_req_access_size_o;
    logic                  mem_data_valid_i;
    logic                  mem_data_is_instr_i;
    logic [LINE_WIDTH-1:0] mem_data_i;
    logic                  mem_write_done_i;

    modport master (
        input  ic_rd_req_i, ic_addr_i, dc_rd_req_i, dc_wr_req_i, dc_addr_i, dc_wr_data_i,
               dc_access_size_i, mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
               mem_write_done_i,
        output ic_data_valid_o, ic_data_o, dc_data_valid_o, dc_data_o, dc_wr_done_o,
               mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
               mem_req_address_o, mem_wr_data_o, mem_req_access_size_o
    );

    modport slave (
        output ic_rd_req_i, ic_addr_i, dc_rd_req_i, dc_wr_req_i, dc_addr_i, dc_wr_data_i,
               dc_access_size_i, mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
               mem_write_done_i,
        input  ic_data_valid_o, ic_data_o, dc_data_valid_o, dc_data_o, dc_wr_done_o,
               mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
               mem_req_address_o, mem_wr_data_o, mem_req_access_size_o
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arb_rr_picker: combinational 2-way round-robin grant, the requester not granted last wins a tie
module mem_arb_rr_picker
    import mem_arbiter_pkg::*;
(
    input  logic     req_ic,
    input  logic     req_dc,
    input  arb_src_t last_grant,
    output logic     grant_valid,
    output arb_src_t grant_src
);

    // Tie goes to whoever did not win last time; otherwise the lone requester
    always_comb begin
        grant_valid = req_ic || req_dc;
        grant_src   = (req_ic && req_dc) ? ((last_grant == SRC_IC) ? SRC_DC : SRC_IC)
                                         : (req_dc ? SRC_DC : SRC_IC);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one icache/dcache line request at a time to main memory and routes the reply.
// Optional macro MEM_ARB_PERF_CNT_EN adds saturating grant and wait-cycle counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.master bus,
    output logic          busy_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_ic_reqs_o,
    output logic [31:0]   perf_dc_reqs_o,
    output logic [31:0]   perf_wait_cycles_o
`endif
);

    arb_state_t            state, state_nx, issued;
    arb_src_t              last_grant, gnt_src;
    logic                  gnt_valid, grant, accept, issuing;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wr_data_q, resp_q;
    access_size_t          size_q;

    mem_arb_rr_picker u_picker (
        .req_ic      (bus.ic_rd_req_i),
        .req_dc      (bus.dc_rd_req_i || bus.dc_wr_req_i),
        .last_grant  (last_grant),
        .grant_valid (gnt_valid),
        .grant_src   (gnt_src)
    );

    // Next state: grant in IDLE (write before fill inside dcache), wait for a correctly tagged reply
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                grant = gnt_valid;
                if (gnt_valid)
                    state_nx = (gnt_src == SRC_IC) ? ISSUE_IC
                             : (bus.dc_wr_req_i ? ISSUE_DC_WR : ISSUE_DC_RD);
            end
            ISSUE_IC:    accept = bus.mem_data_valid_i && bus.mem_data_is_instr_i;
            ISSUE_DC_RD: accept = bus.mem_data_valid_i && !bus.mem_data_is_instr_i;
            ISSUE_DC_WR: accept = bus.mem_write_done_i;
            default:     state_nx = IDLE;
        endcase
        if (accept)
            state_nx = RESP;
    end

    // State register; async reset drops any outstanding transaction
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Request fields are latched at grant so later input changes cannot disturb the memory port
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant <= SRC_DC;
            issued     <= IDLE;
            addr_q     <= '0;
            wr_data_q  <= '0;
            size_q     <= SIZE_BYTE;
        end else if (grant) begin
            last_grant <= gnt_src;
            issued     <= state_nx;
            addr_q     <= (gnt_src == SRC_IC) ? bus.ic_addr_i : bus.dc_addr_i;
            wr_data_q  <= bus.dc_wr_data_i;
            size_q     <= (state_nx == ISSUE_DC_WR) ? bus.dc_access_size_i : SIZE_LINE;
        end
    end

    // Capture read data on the accepted reply; it is presented during RESP
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            resp_q <= '0;
        else if (accept && state != ISSUE_DC_WR)
            resp_q <= bus.mem_data_i;
    end

    // Outputs decode from state so the memory request drops in RESP and on reset
    always_comb begin
        issuing                   = state inside {ISSUE_IC, ISSUE_DC_RD, ISSUE_DC_WR};
        bus.mem_rd_req_valid_o    = (state == ISSUE_IC) || (state == ISSUE_DC_RD);
        bus.mem_wr_req_valid_o    = state == ISSUE_DC_WR;
        bus.mem_req_is_instr_o    = state == ISSUE_IC;
        bus.mem_req_address_o     = issuing ? addr_q : '0;
        bus.mem_wr_data_o         = (state == ISSUE_DC_WR) ? wr_data_q : '0;
        bus.mem_req_access_size_o = issuing ? size_q : SIZE_BYTE;
        bus.ic_data_valid_o       = (state == RESP) && (issued == ISSUE_IC);
        bus.dc_data_valid_o       = (state == RESP) && (issued == ISSUE_DC_RD);
        bus.dc_wr_done_o          = (state == RESP) && (issued == ISSUE_DC_WR);
        bus.ic_data_o             = ((state == RESP) && (issued == ISSUE_IC)) ? resp_q : '0;
        bus.dc_data_o             = ((state == RESP) && (issued == ISSUE_DC_RD)) ? resp_q : '0;
        busy_o                    = state != IDLE;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic ic_wait, dc_wait;

    // A requester is waiting when it asks but is neither granted now nor already being served
    always_comb begin
        ic_wait = bus.ic_rd_req_i && !(grant && gnt_src == SRC_IC) &&
                  !(state == ISSUE_IC || (state == RESP && issued == ISSUE_IC));
        dc_wait = (bus.dc_rd_req_i || bus.dc_wr_req_i) && !(grant && gnt_src == SRC_DC) &&
                  !(state inside {ISSUE_DC_RD, ISSUE_DC_WR} || (state == RESP && issued != ISSUE_IC));
    end

    // Saturating event counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_ic_reqs_o     <= '0;
            perf_dc_reqs_o     <= '0;
            perf_wait_cycles_o <= '0;
        end else begin
            if (grant && gnt_src == SRC_IC && !(&perf_ic_reqs_o))
                perf_ic_reqs_o <= perf_ic_reqs_o + 32'd1;
            if (grant && gnt_src == SRC_DC && !(&perf_dc_reqs_o))
                perf_dc_reqs_o <= perf_dc_reqs_o + 32'd1;
            if ((ic_wait || dc_wait) && !(&perf_wait_cycles_o))
                perf_wait_cycles_o <= perf_wait_cycles_o + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_ic_held: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state == ISSUE_IC) |-> bus.ic_rd_req_i)
        else $error("icache request withdrawn after grant");
    a_dc_rd_held: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state == ISSUE_DC_RD) |-> bus.dc_rd_req_i)
        else $error("dcache read withdrawn after grant");
    a_dc_wr_held: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state == ISSUE_DC_WR) |-> bus.dc_wr_req_i)
        else $error("dcache write withdrawn after grant");
    a_rd_wr_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(bus.mem_rd_req_valid_o && bus.mem_wr_req_valid_o))
        else $error("memory read and write requested together");
`endif

endmodule
